// File: rtl/scpad_wbank_drain_if.sv
// Write-bank handshake bundle: crossbar beat in, per-request completion out.
// master = upstream crossbar/consumer side, slave = scpad_wbank_drain.
interface scpad_wbank_drain_if #(
   parameter int unsigned NUM_COLS  = 32,
   parameter int unsigned ELEM_BITS = 16,
   parameter int unsigned ROW_AW    = 8,
   parameter int unsigned SRC_W     = 2
);
   localparam int unsigned NWR_W = $clog2(NUM_COLS + 1);

   logic                          in_valid;
   logic                          in_ready;
   logic [SRC_W-1:0]              in_src;
   logic [NUM_COLS*ELEM_BITS-1:0] in_wdata;
   logic [NUM_COLS*ROW_AW-1:0]    in_slot;
   logic [NUM_COLS-1:0]           in_vmask;

   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [SRC_W-1:0]              rsp_src;
   logic [NWR_W-1:0]              rsp_nwr;

   modport master (
      output in_valid, in_src, in_wdata, in_slot, in_vmask, rsp_ready,
      input  in_ready, rsp_valid, rsp_src, rsp_nwr
   );

   modport slave (
      input  in_valid, in_src, in_wdata, in_slot, in_vmask, rsp_ready,
      output in_ready, rsp_valid, rsp_src, rsp_nwr
   );
endinterface

// File: rtl/scpad_wbank_drain.sv
// Commits crossbar write beats into the column SRAMs and returns in-order completions.
// Optional SCPAD_WBANK_PERF_EN adds saturating perf_beats / perf_stall counters.
module scpad_wbank_drain #(
   parameter int unsigned NUM_COLS  = 32,
   parameter int unsigned ELEM_BITS = 16,
   parameter int unsigned ROW_AW    = 8,
   parameter int unsigned SRC_W     = 2,
   parameter int unsigned WR_LAT    = 2,
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   scpad_wbank_drain_if.slave            bus,
   output logic [NUM_COLS-1:0]           sram_we,
   output logic [NUM_COLS*ROW_AW-1:0]    sram_addr,
   output logic [NUM_COLS*ELEM_BITS-1:0] sram_wdata
`ifdef SCPAD_WBANK_PERF_EN
   ,
   output logic [31:0]                   perf_beats,
   output logic [31:0]                   perf_stall
`endif
);

   localparam int unsigned NWR_W = $clog2(NUM_COLS + 1);
   localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
   localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

   typedef struct packed {
      logic [SRC_W-1:0] src;
      logic [NWR_W-1:0] nwr;
   } cpl_t;

   logic             accept_c;
   logic [NWR_W-1:0] nwr_c;
   cpl_t             in_cpl_c;
   logic [CNT_W-1:0] used_q;
   logic [CNT_W-1:0] credits_c;

   cpl_t             pipe_q [WR_LAT];
   logic [WR_LAT-1:0] pipe_v_q;

   cpl_t             fifo_q [RSP_DEPTH];
   logic [PTR_W:0]   wr_ptr_q;
   logic [PTR_W:0]   rd_ptr_q;
   logic             empty_c;
   logic             push_c;
   logic             pop_c;
   cpl_t             head_c;

   // used_q counts every beat between accept and pop, pipeline and FIFO alike,
   // so a full FIFO can never be pushed and in_ready never depends on in_valid.
   assign credits_c    = CNT_W'(RSP_DEPTH) - used_q;
   assign bus.in_ready = !rst && (credits_c != '0);
   assign accept_c     = bus.in_valid && bus.in_ready;

   always_comb begin
      nwr_c = '0;
      for (int unsigned i = 0; i < NUM_COLS; i++) begin
         nwr_c = nwr_c + NWR_W'(bus.in_vmask[i]);
      end
   end

   assign in_cpl_c.src = bus.in_src;
   assign in_cpl_c.nwr = nwr_c;

   // S0: register the SRAM strobes; unwritten columns keep their last addr/data
   always_ff @(posedge clk) begin
      if (rst) begin
         sram_we    <= '0;
         sram_addr  <= '0;
         sram_wdata <= '0;
      end else begin
         sram_we <= accept_c ? bus.in_vmask : '0;
         for (int unsigned i = 0; i < NUM_COLS; i++) begin
            if (accept_c && bus.in_vmask[i]) begin
               sram_addr[i*ROW_AW +: ROW_AW]        <= bus.in_slot[i*ROW_AW +: ROW_AW];
               sram_wdata[i*ELEM_BITS +: ELEM_BITS] <= bus.in_wdata[i*ELEM_BITS +: ELEM_BITS];
            end
         end
      end
   end

   // Commit shift register mirrors the SRAM write latency; it never stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_v_q <= '0;
      end else begin
         pipe_v_q[0] <= accept_c;
         for (int unsigned k = 1; k < WR_LAT; k++) begin
            pipe_v_q[k] <= pipe_v_q[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      pipe_q[0] <= in_cpl_c;
      for (int unsigned k = 1; k < WR_LAT; k++) begin
         pipe_q[k] <= pipe_q[k-1];
      end
   end

   assign push_c  = pipe_v_q[WR_LAT-1];
   assign empty_c = (wr_ptr_q == rd_ptr_q);
   assign head_c  = fifo_q[rd_ptr_q[PTR_W-1:0]];

   assign bus.rsp_valid = !rst && !empty_c;
   assign bus.rsp_src   = bus.rsp_valid ? head_c.src : '0;
   assign bus.rsp_nwr   = bus.rsp_valid ? head_c.nwr : '0;
   assign pop_c         = bus.rsp_valid && bus.rsp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         used_q   <= '0;
      end else begin
         if (push_c) begin
            wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
         end
         used_q <= used_q + CNT_W'(accept_c) - CNT_W'(pop_c);
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         fifo_q[wr_ptr_q[PTR_W-1:0]] <= pipe_q[WR_LAT-1];
      end
   end

`ifdef SCPAD_WBANK_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_beats <= '0;
         perf_stall <= '0;
      end else begin
         if (accept_c && (perf_beats != '1)) begin
            perf_beats <= perf_beats + 32'd1;
         end
         if (bus.in_valid && !bus.in_ready && (perf_stall != '1)) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_scpad_wbank_drain.sv
// Directed bench for scpad_wbank_drain with a queue-based completion model.
// Build with SCPAD_WBANK_PERF_EN defined to also cover the perf counters.
module tb_scpad_wbank_drain;
   localparam int unsigned NUM_COLS  = 32;
   localparam int unsigned ELEM_BITS = 16;
   localparam int unsigned ROW_AW    = 8;
   localparam int unsigned SRC_W     = 2;
   localparam int unsigned WR_LAT    = 2;
   localparam int unsigned RSP_DEPTH = 4;
   localparam int unsigned NWR_W     = $clog2(NUM_COLS + 1);

   typedef logic [511:0] wv_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scpad_wbank_drain_if #(.NUM_COLS(NUM_COLS), .ELEM_BITS(ELEM_BITS),
                          .ROW_AW(ROW_AW), .SRC_W(SRC_W)) bus ();

   logic [NUM_COLS-1:0]           sram_we;
   logic [NUM_COLS*ROW_AW-1:0]    sram_addr;
   logic [NUM_COLS*ELEM_BITS-1:0] sram_wdata;
`ifdef SCPAD_WBANK_PERF_EN
   logic [31:0] perf_beats;
   logic [31:0] perf_stall;
`endif

   scpad_wbank_drain #(
      .NUM_COLS(NUM_COLS), .ELEM_BITS(ELEM_BITS), .ROW_AW(ROW_AW),
      .SRC_W(SRC_W), .WR_LAT(WR_LAT), .RSP_DEPTH(RSP_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata)
`ifdef SCPAD_WBANK_PERF_EN
      ,
      .perf_beats (perf_beats),
      .perf_stall (perf_stall)
`endif
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input wv_t act, input wv_t exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Model: every accepted, not yet consumed beat, with its accept cycle.
   typedef struct {
      logic [SRC_W-1:0] src;
      int               nwr;
      int               acc_cyc;
   } beat_t;

   beat_t                         mq[$];
   int                            cyc = 0;
   logic                          model_on = 1'b0;
   logic [NUM_COLS-1:0]           m_we;
   logic [NUM_COLS*ROW_AW-1:0]    m_addr;
   logic [NUM_COLS*ELEM_BITS-1:0] m_wdata;
   logic [31:0]                   m_beats;
   logic [31:0]                   m_stall;

   always @(negedge clk) begin : cmp
      logic m_ready, m_rv, acc, pop;
      cyc++;
      m_ready = !rst && (mq.size() < RSP_DEPTH);
      m_rv    = !rst && (mq.size() > 0) && (mq[0].acc_cyc + int'(WR_LAT) + 1 <= cyc);
      if (model_on) begin
         check("in_ready", wv_t'(bus.in_ready), wv_t'(m_ready));
         check("rsp_valid", wv_t'(bus.rsp_valid), wv_t'(m_rv));
         if (m_rv) begin
            check("rsp_src", wv_t'(bus.rsp_src), wv_t'(mq[0].src));
            check("rsp_nwr", wv_t'(bus.rsp_nwr), wv_t'(mq[0].nwr));
         end
         check("sram_we", wv_t'(sram_we), wv_t'(m_we));
         check("sram_addr", wv_t'(sram_addr), wv_t'(m_addr));
         check("sram_wdata", wv_t'(sram_wdata), wv_t'(m_wdata));
`ifdef SCPAD_WBANK_PERF_EN
         check("perf_beats", wv_t'(perf_beats), wv_t'(m_beats));
         check("perf_stall", wv_t'(perf_stall), wv_t'(m_stall));
`endif
      end
      acc = bus.in_valid && m_ready;
      pop = m_rv && bus.rsp_ready;
      if (rst) begin
         model_on = 1'b1;
         mq.delete();
         m_we    = '0;
         m_addr  = '0;
         m_wdata = '0;
         m_beats = '0;
         m_stall = '0;
      end else begin
         if (pop) void'(mq.pop_front());
         m_we = acc ? bus.in_vmask : '0;
         if (acc) begin
            for (int i = 0; i < int'(NUM_COLS); i++) begin
               if (bus.in_vmask[i]) begin
                  m_addr[i*ROW_AW +: ROW_AW]        = bus.in_slot[i*ROW_AW +: ROW_AW];
                  m_wdata[i*ELEM_BITS +: ELEM_BITS] = bus.in_wdata[i*ELEM_BITS +: ELEM_BITS];
               end
            end
            mq.push_back('{src: bus.in_src, nwr: $countones(bus.in_vmask), acc_cyc: cyc});
            if (m_beats != '1) m_beats = m_beats + 32'd1;
         end
         if (bus.in_valid && !m_ready && (m_stall != '1)) m_stall = m_stall + 32'd1;
      end
   end

   // Per-cycle observations for the directed scenarios
   logic                          o_acc, o_pop, o_rv, o_ready;
   logic [SRC_W-1:0]              o_src;
   logic [NWR_W-1:0]              o_nwr;
   logic [NUM_COLS-1:0]           o_we;
   logic [NUM_COLS*ROW_AW-1:0]    o_addr;
   logic [NUM_COLS*ELEM_BITS-1:0] o_wdata;

   task automatic tick();
      @(negedge clk);
      o_acc   = bus.in_valid && bus.in_ready;
      o_pop   = bus.rsp_valid && bus.rsp_ready;
      o_rv    = bus.rsp_valid;
      o_ready = bus.in_ready;
      o_src   = bus.rsp_src;
      o_nwr   = bus.rsp_nwr;
      o_we    = sram_we;
      o_addr  = sram_addr;
      o_wdata = sram_wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int src, input logic [NUM_COLS-1:0] vmask, input int seed);
      bus.in_src   = SRC_W'(src);
      bus.in_vmask = vmask;
      for (int i = 0; i < int'(NUM_COLS); i++) begin
         bus.in_slot[i*ROW_AW +: ROW_AW]        = ROW_AW'(seed * 7 + i);
         bus.in_wdata[i*ELEM_BITS +: ELEM_BITS] = ELEM_BITS'(seed * 16'h1357 ^ (i * 16'h0101));
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      tick();
      check("rst_in_ready", wv_t'(o_ready), wv_t'(0));
      rst = 1'b0;
      tick();
      check("post_rst_in_ready", wv_t'(o_ready), wv_t'(1));
      check("post_rst_sram_we", wv_t'(o_we), wv_t'(0));
      check("post_rst_sram_addr", wv_t'(o_addr), wv_t'(0));
      check("post_rst_rsp_valid", wv_t'(o_rv), wv_t'(0));
      check("post_rst_rsp_src", wv_t'(o_src), wv_t'(0));
      check("post_rst_rsp_nwr", wv_t'(o_nwr), wv_t'(0));
   endtask

   initial begin
      int nacc, idx, drops, run, maxrun, npop32, nwe, nrv, npop;
      logic chk_next, first;
      int srcs[5];
      int got[$];
      logic [SRC_W-1:0] zs;
      logic [NWR_W-1:0] zn;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.rsp_ready = 1'b0;
      set_beat(0, '0, 0);
      do_reset();

      // Back-pressure fill: 10 cycles of in_valid with rsp_ready low
      srcs = '{0, 1, 2, 3, 0};
      idx  = 0;
      nacc = 0;
      bus.rsp_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         set_beat(srcs[idx], NUM_COLS'(idx + 1), idx + 3);
         tick();
         if (o_acc) begin
            nacc++;
            if (idx < 4) idx++;
         end
      end
      check("bp_accepts", wv_t'(nacc), wv_t'(4));
      check("bp_ready_low", wv_t'(o_ready), wv_t'(0));
`ifdef SCPAD_WBANK_PERF_EN
      check("perf_beats_window", wv_t'(perf_beats), wv_t'(4));
      check("perf_stall_window", wv_t'(perf_stall), wv_t'(6));
`endif
      bus.rsp_ready = 1'b1;
      chk_next = 1'b0;
      first    = 1'b1;
      for (int k = 0; k < 40 && got.size() < 5; k++) begin
         tick();
         if (chk_next) begin
            check("bp_ready_after_pop", wv_t'(o_ready), wv_t'(1));
            chk_next = 1'b0;
         end
         if (o_acc) bus.in_valid = 1'b0;
         if (o_pop) begin
            got.push_back(int'(o_src));
            if (first) begin
               check("bp_ready_at_pop", wv_t'(o_ready), wv_t'(0));
               first    = 1'b0;
               chk_next = 1'b1;
            end
         end
      end
      bus.in_valid = 1'b0;
      check("bp_num_cpl", wv_t'(got.size()), wv_t'(5));
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         check("bp_order", wv_t'(got[i]), wv_t'(srcs[i]));
      end

      // Single write
      do_reset();
      bus.rsp_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_src    = 2'd1;
      bus.in_vmask  = 32'h0000_0005;
      bus.in_slot   = '0;
      bus.in_wdata  = '0;
      bus.in_slot[0*ROW_AW +: ROW_AW]        = 8'h10;
      bus.in_slot[2*ROW_AW +: ROW_AW]        = 8'h22;
      bus.in_wdata[0*ELEM_BITS +: ELEM_BITS] = 16'hAAAA;
      bus.in_wdata[2*ELEM_BITS +: ELEM_BITS] = 16'h5555;
      tick();
      check("sw_accept", wv_t'(o_acc), wv_t'(1));
      bus.in_valid = 1'b0;
      tick();
      check("sw_we", wv_t'(o_we), wv_t'(32'h5));
      check("sw_addr0", wv_t'(o_addr[7:0]), wv_t'(8'h10));
      check("sw_addr2", wv_t'(o_addr[23:16]), wv_t'(8'h22));
      check("sw_data0", wv_t'(o_wdata[15:0]), wv_t'(16'hAAAA));
      check("sw_data2", wv_t'(o_wdata[47:32]), wv_t'(16'h5555));
      tick();
      check("sw_we_once", wv_t'(o_we), wv_t'(0));
      check("sw_rv_early", wv_t'(o_rv), wv_t'(0));
      tick();
      check("sw_rv", wv_t'(o_rv), wv_t'(1));
      check("sw_src", wv_t'(o_src), wv_t'(1));
      check("sw_nwr", wv_t'(o_nwr), wv_t'(2));
      tick();

      // Zero mask
      set_beat(3, '0, 9);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      nwe  = 0;
      npop = 0;
      zs   = '1;
      zn   = '1;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (o_we != '0) nwe++;
         if (o_pop) begin
            npop++;
            zs = o_src;
            zn = o_nwr;
         end
      end
      check("zm_no_we", wv_t'(nwe), wv_t'(0));
      check("zm_cpl", wv_t'(npop), wv_t'(1));
      check("zm_src", wv_t'(zs), wv_t'(3));
      check("zm_nwr", wv_t'(zn), wv_t'(0));

      // Full-mask streaming
      nacc = 0; drops = 0; run = 0; maxrun = 0; npop32 = 0;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (k < 16) set_beat(k, '1, k + 20);
         else bus.in_valid = 1'b0;
         tick();
         if (k < 16) begin
            if (!o_ready) drops++;
            if (o_acc) nacc++;
         end
         if (o_we == '1) begin
            run++;
            if (run > maxrun) maxrun = run;
         end else begin
            run = 0;
         end
         if (o_pop && (o_nwr == NWR_W'(32))) npop32++;
      end
      check("fm_accepts", wv_t'(nacc), wv_t'(16));
      check("fm_no_drop", wv_t'(drops), wv_t'(0));
      check("fm_we_run", wv_t'(maxrun), wv_t'(16));
      check("fm_cpl32", wv_t'(npop32), wv_t'(16));

      // Reset mid-flight
      bus.rsp_ready = 1'b1;
      bus.in_valid  = 1'b1;
      nrv = 0;
      for (int k = 0; k < 3; k++) begin
         set_beat(k + 1, NUM_COLS'(32'h0F0F_0000 >> k), k + 40);
         tick();
         if (o_rv) nrv++;
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      if (o_rv) nrv++;
      rst = 1'b0;
      tick();
      check("mf_we_cleared", wv_t'(o_we), wv_t'(0));
      check("mf_ready", wv_t'(o_ready), wv_t'(1));
      if (o_rv) nrv++;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (o_rv) nrv++;
      end
      check("mf_no_rsp", wv_t'(nrv), wv_t'(0));
      bus.rsp_ready = 1'b0;
      bus.in_valid  = 1'b1;
      nacc = 0;
      for (int k = 0; k < 6; k++) begin
         set_beat(k, NUM_COLS'(k), k + 60);
         tick();
         if (o_acc) nacc++;
      end
      check("mf_credits", wv_t'(nacc), wv_t'(4));
      bus.in_valid  = 1'b0;
      bus.rsp_ready = 1'b1;
      for (int k = 0; k < 10; k++) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
